inst_sram_responder: RTL

AXI4-Lite read-only responder (slave) that terminates the AR/R channels driven by the instruction-fetch unit and returns 32-bit words from an internal SRAM array. It accepts one read at a time, waits a programmable latency, then holds the response until the master accepts it. A side load port lets the simulation loader or bench preload the array. It sits between the fetch unit and the simulation memory model, in place of the external bus for simulation builds.

---
 rtl/inst_sram_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
//
// AXI4-Lite read-only responder for instruction fetch. It terminates the AR/R
// channels, serves one read at a time out of an internal 32-bit SRAM array,
// waits a programmable number of cycles, then holds the response until the
// master accepts it. A side load port writes array words in any state.
//
// Optional feature macro: RSP_RAND_DELAY_EN
//   defined   : delay D = LATENCY + lfsr[2:0]. The lfsr is an 8-bit Fibonacci
//               LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) that advances every cycle.
//   undefined : D = LATENCY, and no LFSR logic is built.
//
// Parameters:
//   BASE_ADDR  - byte address of word 0
//   DEPTH_LOG2 - array holds 2^DEPTH_LOG2 words
//   LATENCY    - idle cycles between AR handshake and first rvalid (0..255)
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   io_slave_ar*        - read address channel (arvalid in, arready out, araddr in)
//   io_slave_r*         - read data channel (rvalid/rresp/rdata out, rready in)
//   load_en/addr/data   - array preload port, one word per cycle
// -----------------------------------------------------------------------------
module inst_sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_slave_arvalid,
  output logic                  io_slave_arready,
  input  logic [31:0]           io_slave_araddr,
  output logic                  io_slave_rvalid,
  input  logic                  io_slave_rready,
  output logic [1:0]            io_slave_rresp,
  output logic [31:0]           io_slave_rdata,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  // Decoded window size in bytes; one extra bit so a 2^30-word array still fits.
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]           sel_addr;
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] index;
  logic [1:0]            dec_rresp;
  logic [31:0]           dec_rdata;
  logic [8:0]            delay;

  // Total delay for a newly accepted read. The random variant can reach
  // 255+7, hence the 9-bit counter.
`ifdef RSP_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign delay  = 9'(LATENCY) + {6'b0, lfsr_q[2:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign delay = 9'(LATENCY);
`endif

  // Address decode. In IDLE the incoming araddr is decoded so a zero-delay
  // read can be answered on the handshake edge; otherwise the latched address
  // is used so loads during WAIT are picked up by the combinational read.
  always_comb begin
    sel_addr  = (state_q == IDLE) ? io_slave_araddr : addr_q;
    offset    = sel_addr - BASE_ADDR;
    in_range  = (sel_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
    index     = offset[DEPTH_LOG2+1:2];
    dec_rresp = RESP_OKAY;
    dec_rdata = mem_q[index];
    if (!in_range) begin
      dec_rresp = RESP_DECERR;
      dec_rdata = '0;
    end else if (sel_addr[1:0] != 2'b00) begin
      dec_rresp = RESP_SLVERR;
      dec_rdata = '0;
    end
  end

  // Next-state logic. Response registers are only loaded on the edge that
  // enters RESP, which keeps rdata/rresp stable for the whole valid phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (io_slave_arvalid) begin
          addr_d = io_slave_araddr;
          if (delay == 9'd0) begin
            state_d = RESP;
            rresp_d = dec_rresp;
            rdata_d = dec_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = delay;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          state_d = RESP;
          rresp_d = dec_rresp;
          rdata_d = dec_rdata;
        end
      end
      RESP: begin
        if (io_slave_rready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

  // Array storage is deliberately outside reset so preloaded code survives it.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign io_slave_arready = (state_q == IDLE);
  assign io_slave_rvalid  = (state_q == RESP);
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rdata   = rdata_q;

endmodule
